hptdc_usb_packer: RTL

// - Downstream drain stage of the HPTDC measurement-word FIFO. Pops 32-bit words one at a time and frames them into packets.
// - Serialises each packet MSB-byte-first onto an FT245-style synchronous byte interface towards the USB bridge.
// - Packet = 4-byte header, N payload words of 4 bytes each, 4-byte trailer carrying N.

---
 rtl/hptdc_usb_packer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hptdc_usb_packer.sv
// Drains 32-bit HPTDC words from the measurement FIFO and frames them as
// header / payload / trailer packets on an FT245-style synchronous byte port.
module hptdc_usb_packer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WORDS  = 256,
    parameter logic [15:0] HDR_MAGIC  = 16'hA55A,
    parameter logic [15:0] TRL_MAGIC  = 16'h5AA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_output_ready,
    input  logic                  usb_txe_n,
    output logic                  usb_wr_n,
    output logic [7:0]            usb_data,
    output logic                  busy,
    output logic [7:0]            pkt_seq
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SEQ_W  = 8;
    localparam int unsigned IDX_W  = 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_TRL  = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q,  hold_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [SEQ_W-1:0]      seq_q,   seq_d;

    logic xfer;
    logic byte_done;
    logic last_byte;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            idx_q   <= IDX_W'(3);
            cnt_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
        end
    end

    // Next-state, datapath update and byte-port outputs
    always_comb begin
        state_d          = state_q;
        hold_d           = hold_q;
        idx_d            = idx_q;
        cnt_d            = cnt_q;
        seq_d            = seq_q;

        xfer      = (state_q == S_HDR) || (state_q == S_SEND) || (state_q == S_TRL);
        byte_done = xfer && !usb_txe_n;
        last_byte = byte_done && (idx_q == IDX_W'(0));

        // Index wraps 0 -> 3 so it is already primed for the next 32-bit register
        if (byte_done) begin
            idx_d = idx_q - IDX_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    hold_d  = DATA_WIDTH'({HDR_MAGIC, seq_q, 8'h00});
                    idx_d   = IDX_W'(3);
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (last_byte) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fifo_output_ready) begin
                    hold_d  = fifo_data_out;
                    idx_d   = IDX_W'(3);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (last_byte) begin
                    if ((cnt_q < CNT_W'(MAX_WORDS)) && !fifo_empty) begin
                        state_d = S_REQ;
                    end else begin
                        hold_d  = DATA_WIDTH'({TRL_MAGIC, cnt_q});
                        idx_d   = IDX_W'(3);
                        state_d = S_TRL;
                    end
                end
            end
            S_TRL: begin
                if (last_byte) begin
                    seq_d   = seq_q + SEQ_W'(1);
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        usb_wr_n         = xfer ? usb_txe_n : 1'b1;
        usb_data         = xfer ? hold_q[{idx_q, 3'b000} +: 8] : 8'h00;
        fifo_read_enable = (state_q == S_REQ);
        busy             = (state_q != S_IDLE);
        pkt_seq          = seq_q;
    end

endmodule
